// File: rtl/gather_sink_controller.sv
// Gather/FC sink: buffers ejected flits, checks packet framing against FCpl,
// drains over valid/ready and returns one credit per drained flit.
// Optional same-cycle bypass when empty: define GATHER_SINK_BYPASS_EN.
module gather_sink_controller #(
  parameter int x_pos = 0,
  parameter int y_pos = 0,
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int FCpl  = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  input  logic [DW-1:0]            in_flit,
  input  logic [1:0]               in_flit_type,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_flit,
  output logic [1:0]               out_flit_type,
  output logic                     credit_ret,
  output logic [$clog2(DEPTH):0]   free_cnt,
  output logic [31:0]              pkt_cnt,
  output logic                     len_err,
  output logic                     seq_err,
  output logic                     ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] TYPE_HEAD = 2'd1;
  localparam logic [1:0] TYPE_BODY = 2'd2;
  localparam logic [1:0] TYPE_TAIL = 2'd3;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RECV = 1'b1;

  logic [DW-1:0] mem_data [DEPTH];
  logic [1:0]    mem_type [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic empty, full, pop, wr, bypass, observe, drop;

  logic [0:0] state;
  logic [7:0] len;
  logic [8:0] len_inc;

  always_comb begin
    empty = (count == '0);
    full  = (count == CW'(DEPTH));
    pop   = !empty && out_ready;
`ifdef GATHER_SINK_BYPASS_EN
    bypass = empty && in_valid && out_ready;
`else
    bypass = 1'b0;
`endif
    // A pop at a full buffer frees the slot the concurrent write lands in.
    wr      = in_valid && !bypass && (!full || pop);
    drop    = in_valid && full && !pop;
    observe = wr || bypass;
    len_inc = {1'b0, len} + 9'd1;
  end

  always_comb begin
    out_valid     = !empty || bypass;
    out_flit      = '0;
    out_flit_type = '0;
    if (bypass) begin
      out_flit      = in_flit;
      out_flit_type = in_flit_type;
    end else if (!empty) begin
      out_flit      = mem_data[rd_ptr];
      out_flit_type = mem_type[rd_ptr];
    end
    free_cnt = CW'(DEPTH) - count;
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_data[wr_ptr] <= in_flit;
      mem_type[wr_ptr] <= in_flit_type;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      credit_ret <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      credit_ret <= pop || bypass;
      if (drop) ovf_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      len     <= '0;
      pkt_cnt <= '0;
      len_err <= 1'b0;
      seq_err <= 1'b0;
    end else if (observe) begin
      case (state)
        S_IDLE: begin
          if (in_flit_type == TYPE_HEAD) begin
            state <= S_RECV;
            len   <= 8'd1;
          end else begin
            seq_err <= 1'b1;
          end
        end
        default: begin
          case (in_flit_type)
            TYPE_HEAD: begin
              seq_err <= 1'b1;
              len     <= 8'd1;
            end
            TYPE_TAIL: begin
              state <= S_IDLE;
              if (len_inc == 9'(FCpl)) pkt_cnt <= pkt_cnt + 1'b1;
              else                     len_err <= 1'b1;
            end
            TYPE_BODY: begin
              if (len != 8'hFF) len <= len_inc[7:0];
            end
            default: begin
              if (len != 8'hFF) len <= len_inc[7:0];
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gather_sink_controller.sv
// Scoreboard bench for gather_sink_controller: directed packets, fill/overflow,
// full-with-pop, framing errors, mid-packet reset and write-to-valid latency.
module tb_gather_sink_controller;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int FCpl = 16;
  localparam logic [1:0] HEAD = 2'd1;
  localparam logic [1:0] BODY = 2'd2;
  localparam logic [1:0] TAIL = 2'd3;
`ifdef GATHER_SINK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_flit = '0;
  logic [1:0]    in_flit_type = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_flit;
  logic [1:0]    out_flit_type;
  logic          credit_ret;
  logic [4:0]    free_cnt;
  logic [31:0]   pkt_cnt;
  logic          len_err, seq_err, ovf_err;

  always #5 clk = ~clk;

  gather_sink_controller #(
    .x_pos(0), .y_pos(0), .DW(DW), .DEPTH(DEPTH), .FCpl(FCpl)
  ) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_flit(in_flit), .in_flit_type(in_flit_type),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_flit(out_flit), .out_flit_type(out_flit_type),
    .credit_ret(credit_ret), .free_cnt(free_cnt), .pkt_cnt(pkt_cnt),
    .len_err(len_err), .seq_err(seq_err), .ovf_err(ovf_err)
  );

  int tests = 0;
  int errors = 0;
  int pops = 0;
  int credits = 0;
  int cr0, pop0;
  logic [33:0] sb [$];
  logic [33:0] mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, pops happen at the next rising edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (credit_ret) credits++;
      if (out_valid && out_ready) begin
        pops++;
        if (sb.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL unexpected_pop: got flit 0x%0h expected none", out_flit);
        end else begin
          mon_e = sb.pop_front();
          chk("out_flit", 64'(out_flit), 64'(mon_e[31:0]));
          chk("out_flit_type", 64'(out_flit_type), 64'(mon_e[33:32]));
        end
      end
    end
  end

  task automatic send(input logic [1:0] t, input logic [31:0] d, input bit push);
    in_valid = 1'b1;
    in_flit = d;
    in_flit_type = t;
    if (push) sb.push_back({t, d});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [31:0] base);
    send(HEAD, base, 1'b1);
    for (int i = 1; i < n - 1; i++) send(BODY, base + 32'(i), 1'b1);
    send(TAIL, base + 32'(n - 1), 1'b1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 200 && (sb.size() != 0 || out_valid); i++) begin
      @(posedge clk); #1;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_flit", 64'(out_flit), 64'd0);
    chk("rst_out_type", 64'(out_flit_type), 64'd0);
    chk("rst_credit", 64'(credit_ret), 64'd0);
    chk("rst_free_cnt", 64'(free_cnt), 64'd16);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_errs", 64'({len_err, seq_err, ovf_err}), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // One full-length packet streamed straight through
    cr0 = credits; pop0 = pops;
    out_ready = 1'b1;
    send_pkt(16, 32'hA000_0000);
    drain();
    chk("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);
    chk("t1_errs", 64'({len_err, seq_err}), 64'd0);
    chk("t1_credits", 64'(credits - cr0), 64'd16);
    chk("t1_pops", 64'(pops - pop0), 64'd16);
    chk("t1_free_cnt", 64'(free_cnt), 64'd16);

    // Fill with no consumer
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("t2_free_cnt", 64'(free_cnt), 64'(16 - i));
      send((i == 0) ? HEAD : ((i == 15) ? TAIL : BODY), 32'hB000_0000 + 32'(i), 1'b1);
    end
    chk("t2_free_full", 64'(free_cnt), 64'd0);
    chk("t2_pkt_cnt", 64'(pkt_cnt), 64'd2);
    chk("t2_ovf_clear", 64'(ovf_err), 64'd0);

    // Full buffer: concurrent write and pop is accepted
    out_ready = 1'b1;
    send(HEAD, 32'hC000_0000, 1'b1);
    out_ready = 1'b0;
    chk("t3_free_cnt", 64'(free_cnt), 64'd0);
    chk("t3_ovf_clear", 64'(ovf_err), 64'd0);
    chk("t3_credit", 64'(credit_ret), 64'd1);

    // Write while full without pop is dropped
    send(BODY, 32'hDEAD_BEEF, 1'b0);
    chk("t3_ovf_set", 64'(ovf_err), 64'd1);
    chk("t3_free_after_drop", 64'(free_cnt), 64'd0);

    out_ready = 1'b1;
    for (int i = 1; i < 15; i++) send(BODY, 32'hC000_0000 + 32'(i), 1'b1);
    send(TAIL, 32'hC000_000F, 1'b1);
    drain();
    chk("t3_pkt_cnt", 64'(pkt_cnt), 64'd3);
    chk("t3_errs", 64'({len_err, seq_err}), 64'd0);

    // Short packet, then a stray BODY in IDLE
    send_pkt(7, 32'hE000_0000);
    chk("t4_len_err", 64'(len_err), 64'd1);
    chk("t4_pkt_cnt", 64'(pkt_cnt), 64'd3);
    chk("t4_seq_clear", 64'(seq_err), 64'd0);
    send(BODY, 32'h0000_00F0, 1'b1);
    chk("t4_seq_err", 64'(seq_err), 64'd1);
    drain();

    // Reset with a partial packet buffered
    out_ready = 1'b0;
    send(HEAD, 32'h7000_0000, 1'b1);
    for (int i = 1; i < 5; i++) send(BODY, 32'h7000_0000 + 32'(i), 1'b1);
    chk("t5_free_cnt", 64'(free_cnt), 64'd11);
    rstn = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    #1;
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_free_rst", 64'(free_cnt), 64'd16);
    chk("t5_credit", 64'(credit_ret), 64'd0);
    chk("t5_errs", 64'({len_err, seq_err, ovf_err}), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    cr0 = credits;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("t5_no_credit", 64'(credits - cr0), 64'd0);
    send_pkt(16, 32'h1000_0000);
    drain();
    chk("t5_pkt_cnt", 64'(pkt_cnt), 64'd1);
    chk("t5_len_err", 64'(len_err), 64'd0);

    // Write-to-out_valid latency on an empty buffer
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_flit = 32'h5555_0000;
    in_flit_type = HEAD;
    sb.push_back({HEAD, 32'h5555_0000});
    #2;
    chk("t6_valid_same", 64'(out_valid), 64'(BYP));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t6_valid_next", 64'(out_valid), 64'(!BYP));
    chk("t6_credit_next", 64'(credit_ret), 64'(BYP));
    @(posedge clk); #1;
    chk("t6_credit_late", 64'(credit_ret), 64'(!BYP));
    drain();

    chk("credit_invariant", 64'(credits), 64'(pops));
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/gather_sink_controller.md
Name: gather_sink_controller

Overview:
- Terminal end of the gather/FC credit loop.
- Sits at the gather destination ejection port. Accepts flits from the router local output into a DEPTH-entry credit buffer and checks packet framing and length against FCpl.
- Drains flits to the local consumer over a valid/ready interface.
- Returns one credit pulse upstream per drained flit. These pulses feed the credit counter at the FC start port.

Parameters:
- x_pos, 0, tile X coordinate; used for identification only.
- y_pos, 0, tile Y coordinate; used for identification only.
- DW, 32, flit payload width.
- DEPTH, 16, buffer entries; equals credits granted upstream; power of two, >=2.
- FCpl, 16, expected FC packet length in flits, HEAD and TAIL included; >=2.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- in_valid  in  1  flit present from router ejection
- in_flit  in  DW  flit payload
- in_flit_type  in  2  `HEAD/`BODY/`TAIL encoding from params.svh
- out_valid  out  1  flit available to consumer
- out_ready  in  1  consumer accepts
- out_flit  out  DW  payload at buffer head
- out_flit_type  out  2  type at buffer head
- credit_ret  out  1  one-cycle pulse, one credit returned upstream
- free_cnt  out  $clog2(DEPTH)+1  free entries
- pkt_cnt  out  32  completed well-formed packets
- len_err  out  1  sticky: packet length != FCpl
- seq_err  out  1  sticky: illegal type sequence
- ovf_err  out  1  sticky: write while full

Behaviour:
- Reset values: out_valid=0, out_flit=0, out_flit_type=0, credit_ret=0, free_cnt=DEPTH, pkt_cnt=0, all error flags=0.
- Reset asserted mid-packet discards buffer contents and returns the FSM to IDLE. No credits are returned for discarded flits.
- Write side:
  - in_valid with buffer not full: write at posedge.
  - in_valid while full: flit dropped, ovf_err set, buffer and pointers unchanged.
  - No ready/backpressure to the router; credits guarantee space.
- Read side:
  - out_valid = buffer non-empty.
  - Pop on out_valid & out_ready at posedge.
  - Default write-to-out_valid latency is 1 cycle (registered, no bypass).
- Simultaneous write and pop (not full): occupancy unchanged. When full, a simultaneous pop frees an entry, so the write is accepted; full is evaluated before pop only when out_ready=0.
- Pointers: $clog2(DEPTH) bits, wrap naturally; full/empty derived from a count register.
- free_cnt = DEPTH - occupancy, updated the same cycle as the pointers.
- credit_ret: registered; asserted the cycle after each pop; back-to-back pops give back-to-back pulses.
  - Invariant: total credit_ret pulses = total pops.
- Framing FSM observes accepted writes only; dropped flits are ignored by the FSM.
  - IDLE:
    - HEAD -> RECV, len=1.
    - BODY or TAIL -> seq_err=1, stay IDLE; the flit is still buffered.
  - RECV:
    - BODY -> len+1; saturates at 255.
    - TAIL -> IDLE. If len+1==FCpl, pkt_cnt+1; else len_err=1 and pkt_cnt is not incremented.
    - HEAD -> seq_err=1, len=1, stay RECV (treated as a new packet).
- A HEAD+TAIL-only packet (len 2) is valid when FCpl==2.
- pkt_cnt wraps at 2^32.
- Error flags are sticky until reset.

Optional Feature:
- GATHER_SINK_BYPASS_EN defined:
  - When the buffer is empty, in_valid=1 and out_ready=1, the flit passes combinationally in the same cycle.
  - out_valid=1, out_flit=in_flit; the flit is not written to the buffer.
  - credit_ret still pulses the next cycle.
  - The FSM observes the flit.
- Macro undefined: 1-cycle minimum latency, as in Behaviour.

Test Plan:
- Reset, then one 16-flit packet (HEAD, 14 BODY, TAIL) with out_ready=1 -> pkt_cnt=1, 16 credit_ret pulses, len_err=seq_err=0, out order equals in order.
- out_ready=0 while writing 16 flits -> free_cnt counts 16..0; a 17th write sets ovf_err, drops the flit, free_cnt stays 0.
- Full buffer, then in_valid and out_ready together -> write accepted, free_cnt stays 0, no ovf_err, one credit_ret next cycle.
- Packet HEAD, 5 BODY, TAIL (7 flits) -> len_err=1, pkt_cnt unchanged. Stray BODY in IDLE -> seq_err=1.
- Assert rstn low with 5 flits buffered mid-packet -> out_valid=0, free_cnt=16, no credit_ret. A following good packet -> pkt_cnt=1.
- Bypass build, empty buffer, out_ready=1, single HEAD write -> out_valid in the same cycle as in_valid, credit_ret next cycle. Non-bypass build -> out_valid one cycle later.
